// File: rtl/memif2_pkg.sv
// Shared definitions for the memif2 host-to-memory bridge.
// Register offsets, CSR bits and FSM encodings.
package memif2_pkg;

  localparam logic [1:0] REG_ADDR = 2'd0;
  localparam logic [1:0] REG_DLO  = 2'd1;
  localparam logic [1:0] REG_DHI  = 2'd2;
  localparam logic [1:0] REG_CSR  = 2'd3;

  localparam int CSR_AINC = 0;
  localparam int CSR_ERR  = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MRD  = 2'd1,
    S_MWR  = 2'd2,
    S_ACK  = 2'd3
  } state_e;

endpackage

// File: rtl/memif2_tmo.sv
// Memory-wait timeout counter for memif2.
// Cleared by load, advanced by count; expire flags the last stalled cycle.
module memif2_tmo #(
  parameter int TMO = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || load_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = (TMO > 0) && count_i && (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/memif2.sv
// Host register window onto a wide word memory.
// DHI write / DLO read perform the memory access; the rest is local.
module memif2
  import memif2_pkg::*;
#(
  parameter int AW  = 18,
  parameter int DW  = 36,
  parameter int SW  = 32,
  parameter int TMO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    s_address,
  input  logic          s_write,
  input  logic          s_read,
  input  logic [SW-1:0] s_writedata,
  output logic [SW-1:0] s_readdata,
  output logic          s_waitrequest,
  output logic [AW-1:0] m_address,
  output logic          m_write,
  output logic          m_read,
  output logic [DW-1:0] m_writedata,
  input  logic [DW-1:0] m_readdata,
  input  logic          m_waitrequest
);

  localparam int HW = DW / 2;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] maddr_q;
  logic [HW-1:0] wlo_q;
  logic [HW-1:0] whi_q;
  logic          ainc_q;
  logic          err_q;
  logic          swait_q;
  logic          mrd_q;
  logic          mwr_q;
  logic [SW-1:0] rdata_q;
  logic [DW-1:0] mwd_q;
  logic          busy;
  logic          expire;
  logic [AW-1:0] addr_inc;

  assign busy     = (state_q == S_MRD) || (state_q == S_MWR);
  assign addr_inc = ainc_q ? addr_q + AW'(1) : addr_q;

  memif2_tmo #(.TMO(TMO)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load_i   (!busy),
    .count_i  (busy && m_waitrequest),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      maddr_q <= '0;
      wlo_q   <= '0;
      whi_q   <= '0;
      ainc_q  <= 1'b0;
      err_q   <= 1'b0;
      swait_q <= 1'b1;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      rdata_q <= '0;
      mwd_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (s_write || s_read) begin
            state_q <= S_ACK;
            swait_q <= 1'b0;
            if (s_write) begin
              case (s_address)
                REG_ADDR: addr_q <= s_writedata[AW-1:0];
                REG_DLO:  wlo_q  <= s_writedata[HW-1:0];
                REG_DHI: begin
                  whi_q   <= s_writedata[HW-1:0];
                  state_q <= S_MWR;
                  swait_q <= 1'b1;
                  mwr_q   <= 1'b1;
                  maddr_q <= addr_q;
                  mwd_q   <= {s_writedata[HW-1:0], wlo_q};
                end
                default: begin
                  ainc_q <= s_writedata[CSR_AINC];
                  if (s_writedata[CSR_ERR]) err_q <= 1'b0;
                end
              endcase
            end else begin
              case (s_address)
                REG_ADDR: rdata_q <= SW'(addr_q);
                REG_DLO: begin
                  state_q <= S_MRD;
                  swait_q <= 1'b1;
                  mrd_q   <= 1'b1;
                  maddr_q <= addr_q;
                end
                REG_DHI: begin
                  rdata_q <= SW'(whi_q);
                  addr_q  <= addr_inc;
                end
                default: rdata_q <= SW'({err_q, ainc_q});
              endcase
            end
          end
        end
        S_MRD, S_MWR: begin
          if (!m_waitrequest) begin
            state_q <= S_ACK;
            swait_q <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            if (state_q == S_MRD) begin
              {whi_q, wlo_q} <= m_readdata;
              rdata_q        <= SW'(m_readdata[HW-1:0]);
            end else begin
              addr_q <= addr_inc;
            end
          end else if (expire) begin
            // Abandon the stalled access; local data and address stay put.
            state_q <= S_ACK;
            swait_q <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            err_q   <= 1'b1;
            if (state_q == S_MRD) rdata_q <= '1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          swait_q <= 1'b1;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign s_readdata    = rdata_q;
  assign s_waitrequest = swait_q;
  assign m_address     = maddr_q;
  assign m_write       = mwr_q;
  assign m_read        = mrd_q;
  assign m_writedata   = mwd_q;

endmodule

// File: doc/memif2.md
MEMIF2 -- requirements
Module: memif2

Interface
REQ-001 Parameters SHALL be:
- AW, 18, memory word address width.
- DW, 36, memory word width; even; DW/2 <= SW.
- SW, 32, host data width.
- TMO, 0, memory-wait timeout in cycles; 0 disables timeout.

REQ-002 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- s_address  in  2  host register select: 0 ADDR, 1 DLO, 2 DHI, 3 CSR.
- s_write  in  1  host write request.
- s_read  in  1  host read request.
- s_writedata  in  SW  host write data.
- s_readdata  out  SW  host read data.
- s_waitrequest  out  1  low exactly on the host completion cycle.
- m_address  out  AW  memory word address.
- m_write  out  1  memory write request.
- m_read  out  1  memory read request.
- m_writedata  out  DW  memory write data.
- m_readdata  in  DW  memory read data.
- m_waitrequest  in  1  memory stall.

Function
REQ-003 Internal state SHALL be ADDR[AW], WLO[DW/2], WHI[DW/2] and CSR{AINC, ERR}; WLO is the low half and WHI the high half of the data word.
REQ-004 The FSM SHALL have states IDLE, MRD, MWR and ACK.
- IDLE samples s_read|s_write; s_write wins if both are high.
- ACK drives s_waitrequest=0 for one cycle, then returns to IDLE.
REQ-005 s_waitrequest SHALL be 1 in every state except ACK.
REQ-006 ADDR, CSR and DLO-write accesses SHALL reach ACK on the cycle after they are sampled; host latency is 2 edges.
REQ-007 A write to ADDR SHALL load ADDR with s_writedata[AW-1:0].
REQ-008 A write to CSR SHALL load AINC from bit 0; writing 1 to bit 1 SHALL clear ERR.
REQ-009 A write to DLO SHALL load WLO only, with no memory access.
REQ-010 A write to DHI SHALL load WHI, then enter MWR with m_writedata={s_writedata[DW/2-1:0],WLO}.
REQ-011 A DLO read SHALL enter MRD; m_readdata SHALL be captured into {WHI,WLO} at the edge where m_waitrequest=0; s_readdata SHALL then return WLO zero-extended.
REQ-012 A DHI read SHALL return WHI zero-extended with no memory access; latency is as REQ-006.
REQ-013 ADDR, CSR reads SHALL return ADDR zero-extended and {ERR,AINC} in bits [1:0] respectively.
REQ-014 m_read/m_write SHALL assert on entering MRD/MWR and hold, with m_address and m_writedata stable, until the edge where m_waitrequest=0; the same edge SHALL move the FSM to ACK.
REQ-015 If AINC=1, ADDR SHALL increment modulo 2^AW on the ACK of a DHI write or DHI read.
- From all-ones, ADDR wraps to 0.
REQ-016 If TMO>0 and m_waitrequest stays high for TMO cycles in MRD/MWR:
- the request SHALL drop;
- ERR SHALL be set;
- the FSM SHALL go to ACK;
- read data SHALL be all-ones;
- WHI/WLO and ADDR SHALL be unchanged.
REQ-017 s_readdata SHALL be valid only in ACK and SHALL otherwise be 0.
REQ-018 Host requests arriving while not in IDLE SHALL be ignored until IDLE; the host is required to hold them.

Reset
REQ-019 The clk edge with reset=1 SHALL set the FSM to IDLE and clear ADDR, WLO, WHI, AINC, ERR and the timeout counter.
- At that edge, s_waitrequest=1, m_read=0, m_write=0, m_address=0, m_writedata=0 and s_readdata=0.
REQ-020 Reset during MRD/MWR SHALL abort the memory request at that edge with no ACK issued.

Structure
REQ-021 Register offsets (ADDR=0, DLO=1, DHI=2, CSR=3), CSR bit positions and FSM state encodings SHALL live in a shared package/include used by RTL and bench.
REQ-022 The timeout counter SHALL be one sub-module, memif2_tmo (load, count, expire); the rest is a single FSM module.

Verification
REQ-023 Bench SHALL use defaults with a delayed-waitrequest memory model, and SHALL cover:
- mem[0o123]=0o112233445566; write ADDR=0o123, read DLO -> 0o445566 after one m_read; read DHI -> 0o112233 with no m_read.
- Write ADDR=0o200, DLO=0o111222, DHI=0o333444 -> single m_write, mem[0o200]=0o333444111222.
- CSR AINC=1, ADDR=0o777777; DLO/DHI write -> mem[0o777777] written, ADDR reads 0.
- TMO=16, memory never drops waitrequest; DLO read -> m_read high 16 cycles, s_readdata=0xFFFFFFFF, CSR reads 2; CSR write 2 -> CSR reads 0.
- Reset asserted mid-MRD -> m_read=0 the next edge, no s_waitrequest low pulse, ADDR reads 0.
- Simultaneous s_read and s_write to DHI -> write performed, one ACK.
